// File: rtl/id_ex_stage_pkg.sv
// Shared widths, control-bundle bit positions and types for the ID->EX stage.
package id_ex_stage_pkg;
  localparam int DATA_W         = 24;
  localparam int REG_ADDR_W     = 4;
  localparam int CTRL_W         = 8;
  localparam int NUM_OPS        = 2;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;

  typedef logic [CTRL_W-1:0]     ctrl_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [REG_ADDR_W-1:0] reg_t;

  localparam reg_t REG_ZERO = '0;

  // Register-address match that never fires for $zero.
  function automatic logic reg_hit(input reg_t a, input reg_t b);
    return (a == b) && (a != REG_ZERO);
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/writeback/execute signal bundle seen by the ID->EX register.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;
  logic  in_valid, in_ready;
  reg_t  id_rs1, id_rs2, id_rd;
  data_t id_rd1_data, id_rd2_data, id_imm;
  ctrl_t id_ctrl;
  logic  wb_write_en;
  reg_t  wb_write_dest;
  data_t wb_write_data;
  logic  flush, ex_ready, ex_valid, load_use_stall;
  reg_t  ex_rs1, ex_rs2, ex_rd;
  data_t ex_op1, ex_op2, ex_imm;
  ctrl_t ex_ctrl;

  modport slave (
    input  in_valid, id_rs1, id_rs2, id_rd, id_rd1_data, id_rd2_data, id_imm, id_ctrl,
           wb_write_en, wb_write_dest, wb_write_data, flush, ex_ready,
    output in_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl,
           load_use_stall
  );
  modport master (
    output in_valid, id_rs1, id_rs2, id_rd, id_rd1_data, id_rd2_data, id_imm, id_ctrl,
           wb_write_en, wb_write_dest, wb_write_data, flush, ex_ready,
    input  in_ready, ex_valid, ex_rs1, ex_rs2, ex_rd, ex_op1, ex_op2, ex_imm, ex_ctrl,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// Per-operand writeback bypass: capture-time select plus held-operand snoop match.
module operand_bypass
  import id_ex_stage_pkg::*;
(
  input  reg_t  id_rs,
  input  data_t id_data,
  input  reg_t  ex_rs,
  input  logic  wb_en,
  input  reg_t  wb_dest,
  input  data_t wb_data,
  output data_t cap_op,
  output logic  snoop_hit
);
  logic cap_hit;

  assign cap_hit   = wb_en & reg_hit(id_rs, wb_dest);
  // $zero reads as 0 even if the regfile port returns garbage.
  assign cap_op    = (id_rs == REG_ZERO) ? '0 : (cap_hit ? wb_data : id_data);
  assign snoop_hit = wb_en & reg_hit(ex_rs, wb_dest);
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with writeback bypass, load-use bubble, hold and flush.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);
  logic                              vld;
  ctrl_t                             ctrl_q;
  reg_t                              rd_q;
  data_t                             imm_q;
  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] rs_q;
  logic [NUM_OPS-1:0][DATA_W-1:0]     op_q;
  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] id_rs;
  logic [NUM_OPS-1:0][DATA_W-1:0]     id_data;
  logic [NUM_OPS-1:0][DATA_W-1:0]     cap_op;
  logic [NUM_OPS-1:0]                 snoop_hit;
  logic advance, lus, accept;

  assign id_rs   = {bus.id_rs2, bus.id_rs1};
  assign id_data = {bus.id_rd2_data, bus.id_rd1_data};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_byp
    operand_bypass u_byp (
      .id_rs    (id_rs[g]),
      .id_data  (id_data[g]),
      .ex_rs    (rs_q[g]),
      .wb_en    (bus.wb_write_en),
      .wb_dest  (bus.wb_write_dest),
      .wb_data  (bus.wb_write_data),
      .cap_op   (cap_op[g]),
      .snoop_hit(snoop_hit[g])
    );
  end

  assign advance = !vld | bus.ex_ready;
  // Stall is visible even while EX backpressures, so upstream sees a steady hold.
  assign lus     = bus.in_valid & vld & ctrl_q[CTRL_MEM_READ] & (rd_q != REG_ZERO) &
                   ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
  assign bus.in_ready       = advance & !lus & !bus.flush;
  assign accept             = bus.in_valid & bus.in_ready;
  assign bus.load_use_stall = lus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= 1'b0;
      ctrl_q <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      op_q   <= '0;
    end else if (bus.flush) begin
      vld    <= 1'b0;
      ctrl_q <= '0;
    end else if (advance) begin
      vld <= accept;
      if (accept) begin
        ctrl_q <= bus.id_ctrl;
        rd_q   <= bus.id_rd;
        imm_q  <= bus.id_imm;
        rs_q   <= id_rs;
        op_q   <= cap_op;
      end else begin
        ctrl_q <= '0;
      end
    end else begin
      // Held instruction keeps tracking writebacks to its sources.
      for (int i = 0; i < NUM_OPS; i++)
        if (snoop_hit[i]) op_q[i] <= bus.wb_write_data;
    end
  end

  assign bus.ex_valid = vld;
  assign bus.ex_ctrl  = ctrl_q;
  assign bus.ex_rd    = rd_q;
  assign bus.ex_imm   = imm_q;
  assign bus.ex_rs1   = rs_q[0];
  assign bus.ex_rs2   = rs_q[1];
  assign bus.ex_op1   = op_q[0];
  assign bus.ex_op2   = op_q[1];
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: bypass, load-use, hold snoop, flush, stream, reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input reg_t rs1, input reg_t rs2, input reg_t rd,
                       input data_t d1, input data_t d2, input data_t imm, input ctrl_t ctrl);
    bus.in_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_rd1_data = d1;
    bus.id_rd2_data = d2;
    bus.id_imm      = imm;
    bus.id_ctrl     = ctrl;
  endtask

  task automatic wb(input logic en, input reg_t dest, input data_t data);
    bus.wb_write_en   = en;
    bus.wb_write_dest = dest;
    bus.wb_write_data = data;
  endtask

  initial begin
    drive(1'b0, 4'd0, 4'd0, 4'd0, 24'h0, 24'h0, 24'h0, 8'h00);
    wb(1'b0, 4'd0, 24'h0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ctrl",  32'(bus.ex_ctrl),  32'd0);
    chk("rst_op1",   32'(bus.ex_op1),   32'd0);
    chk("rst_rd",    32'(bus.ex_rd),    32'd0);
    rst = 1'b1;
    tick();

    // Capture-time bypass on rs1
    drive(1'b1, 4'd3, 4'd4, 4'd6, 24'h50000, 24'h0AAAA, 24'h000111, 8'h01);
    wb(1'b1, 4'd3, 24'h12345);
    #1 chk("byp_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("byp_valid", 32'(bus.ex_valid), 32'd1);
    chk("byp_op1",   32'(bus.ex_op1),   32'h12345);
    chk("byp_op2",   32'(bus.ex_op2),   32'h0AAAA);
    chk("byp_rd",    32'(bus.ex_rd),    32'd6);
    chk("byp_imm",   32'(bus.ex_imm),   32'h111);
    chk("byp_ctrl",  32'(bus.ex_ctrl),  32'h01);

    // $zero source ignores both regfile data and a wb to r0
    drive(1'b1, 4'd0, 4'd4, 4'd6, 24'h000777, 24'h0AAAA, 24'h000111, 8'h01);
    wb(1'b1, 4'd0, 24'h000999);
    tick();
    chk("zero_op1", 32'(bus.ex_op1), 32'd0);

    // Load-use bubble
    wb(1'b0, 4'd0, 24'h0);
    drive(1'b1, 4'd1, 4'd2, 4'd5, 24'h1, 24'h2, 24'h0, 8'h03);
    tick();
    drive(1'b1, 4'd8, 4'd5, 4'd9, 24'h8, 24'h5, 24'h000022, 8'h01);
    #1;
    chk("lu_stall",    32'(bus.load_use_stall), 32'd1);
    chk("lu_in_ready", 32'(bus.in_ready),       32'd0);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_bubble_ctrl",  32'(bus.ex_ctrl),  32'd0);
    chk("lu_retry_ready",  32'(bus.in_ready), 32'd1);
    tick();
    chk("lu_acc_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_acc_rd",    32'(bus.ex_rd),    32'd9);
    chk("lu_acc_rs2",   32'(bus.ex_rs2),   32'd5);

    // Backpressure with snoop on ex_rs2=7
    drive(1'b1, 4'd6, 4'd7, 4'd10, 24'h000100, 24'h000200, 24'h000033, 8'h05);
    tick();
    bus.ex_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd2, 4'd3, 24'h0, 24'h0, 24'h0, 8'h01);
    for (int k = 0; k < 3; k++) begin
      wb(1'b1, 4'd7, 24'hA0000 + 24'(k));
      #1 chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("bp_op2",   32'(bus.ex_op2),   32'hA0000 + 32'(k));
      chk("bp_op1",   32'(bus.ex_op1),   32'h100);
      chk("bp_rd",    32'(bus.ex_rd),    32'd10);
      chk("bp_imm",   32'(bus.ex_imm),   32'h33);
      chk("bp_valid", 32'(bus.ex_valid), 32'd1);
    end

    // Flush while backpressured
    wb(1'b0, 4'd0, 24'h0);
    bus.flush = 1'b1;
    #1 chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("fl_valid", 32'(bus.ex_valid), 32'd0);
    chk("fl_ctrl",  32'(bus.ex_ctrl),  32'd0);
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;

    // Load-use while EX is stalled: hold, stall stays asserted
    drive(1'b1, 4'd1, 4'd2, 4'd11, 24'h1, 24'h2, 24'h0, 8'h02);
    tick();
    bus.ex_ready = 1'b0;
    drive(1'b1, 4'd11, 4'd2, 4'd12, 24'h0, 24'h0, 24'h0, 8'h01);
    #1 chk("lubp_stall0", 32'(bus.load_use_stall), 32'd1);
    tick();
    chk("lubp_stall1", 32'(bus.load_use_stall), 32'd1);
    chk("lubp_valid",  32'(bus.ex_valid),       32'd1);
    chk("lubp_rd",     32'(bus.ex_rd),          32'd11);
    bus.ex_ready = 1'b1;
    tick();
    chk("lubp_bubble", 32'(bus.ex_valid), 32'd0);

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, reg_t'(i), 4'd0, reg_t'(i + 1), 24'h10000 + 24'(i), 24'h0,
            24'h1111 * 24'(i) + 24'h1, 8'h01);
      tick();
      chk("st_valid", 32'(bus.ex_valid), 32'd1);
      chk("st_imm",   32'(bus.ex_imm),   32'h1111 * 32'(i) + 32'h1);
      chk("st_rd",    32'(bus.ex_rd),    32'(i + 1));
      chk("st_op1",   32'(bus.ex_op1),   (i == 0) ? 32'd0 : 32'h10000 + 32'(i));
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0, 24'h0, 24'h0, 24'h0, 8'h00);
    tick();
    chk("st_drain", 32'(bus.ex_valid), 32'd0);

    // Async reset mid-operation
    drive(1'b1, 4'd2, 4'd3, 4'd4, 24'h00ABCD, 24'h1, 24'h2, 8'h01);
    tick();
    chk("mr_pre_valid", 32'(bus.ex_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.ex_valid), 32'd0);
    chk("mr_ctrl",  32'(bus.ex_ctrl),  32'd0);
    chk("mr_op1",   32'(bus.ex_op1),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
